// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg : shared fetch-stage types and constants            rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package if_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if : SRAM-like instruction bus (request + response)  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface if_fetch_unit_if;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );

endinterface

`default_nettype wire

// File: rtl/if_pc_mux.sv
// ---------------------------------------------------------------------------
// if_pc_mux : next-PC select, redirect > sequential step > hold   rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module if_pc_mux
  import if_pkg::*;
#(
  parameter logic [31:0] PC_STEP = PC_STEP_DEFAULT
) (
  input  logic [31:0] pc,
  input  logic [31:0] br_target,
  input  logic        sel_br,
  input  logic        sel_step,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc;
    if (sel_br) begin
      next_pc = br_target;
    end else if (sel_step) begin
      next_pc = pc + PC_STEP;
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit : IF stage, PC owner, single-outstanding fetch   rev 1.0
// Optional macro IF_ADEF_EN: misaligned-PC fetch exception instead of bus issue.
// ---------------------------------------------------------------------------
`default_nettype none

module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic                   clk,
  input  logic                   resetn,
  if_fetch_unit_if.master        bus,
  input  logic                   br_taken,
  input  logic [31:0]            br_target,
  input  logic                   id_allowin,
  output logic                   if_valid,
  output logic [31:0]            if_pc,
  output logic [31:0]            if_inst,
  output logic                   if_ex
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic         cancel, cancel_nxt;
  logic         sel_br, sel_step, capture, req;
`ifdef IF_ADEF_EN
  logic         raise_ex;
`endif

  if_pc_mux #(.PC_STEP(PC_STEP)) u_pc_mux (
    .pc        (pc),
    .br_target (br_target),
    .sel_br    (sel_br),
    .sel_step  (sel_step),
    .next_pc   (pc_nxt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      cancel <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      cancel <= cancel_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cancel_nxt = cancel;
    sel_br     = 1'b0;
    sel_step   = 1'b0;
    capture    = 1'b0;
    req        = 1'b0;
`ifdef IF_ADEF_EN
    raise_ex   = 1'b0;
`endif
    unique case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        req = 1'b1;
`ifdef IF_ADEF_EN
        // A misaligned PC never reaches the bus; a redirect still wins.
        if (pc[1:0] != 2'b00) begin
          req = 1'b0;
          if (br_taken) begin
            sel_br = 1'b1;
          end else begin
            raise_ex  = 1'b1;
            state_nxt = S_HOLD;
          end
        end else
`endif
        if (br_taken) begin
          sel_br = 1'b1;
          if (bus.inst_addr_ok) begin
            cancel_nxt = 1'b1;
            state_nxt  = S_WAIT;
          end
        end else if (bus.inst_addr_ok) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        sel_br = br_taken;
        if (bus.inst_data_ok) begin
          if (cancel || br_taken) begin
            cancel_nxt = 1'b0;
            state_nxt  = S_REQ;
          end else begin
            capture   = 1'b1;
            state_nxt = S_HOLD;
          end
        end else if (br_taken) begin
          cancel_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        // Redirect squashes the held instruction even if ID accepts it.
        if (br_taken) begin
          sel_br    = 1'b1;
          state_nxt = S_REQ;
        end else if (id_allowin) begin
          sel_step  = 1'b1;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      if_pc   <= RESET_PC;
      if_inst <= NOP_INST;
    end else if (capture) begin
      if_pc   <= pc;
      if_inst <= bus.inst_rdata;
    end
`ifdef IF_ADEF_EN
    else if (raise_ex) begin
      if_pc   <= pc;
      if_inst <= NOP_INST;
    end
`endif
  end

`ifdef IF_ADEF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      if_ex <= 1'b0;
    end else if (raise_ex) begin
      if_ex <= 1'b1;
    end else if (state == S_HOLD && state_nxt != S_HOLD) begin
      if_ex <= 1'b0;
    end
  end
`else
  assign if_ex = 1'b0;
`endif

  assign if_valid      = (state == S_HOLD);
  assign bus.inst_req  = req;
  assign bus.inst_addr = pc;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit : directed self-checking bench for if_fetch_unit   rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_if_fetch_unit;
  import if_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        br_taken;
  logic [31:0] br_target;
  logic        id_allowin;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ex;

  integer n_cmp  = 0;
  integer n_fail = 0;

  if_fetch_unit_if bus ();

  if_fetch_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .id_allowin (id_allowin),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .if_ex      (if_ex)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in S_IDLE, just after a rising edge.
  task automatic apply_reset;
    resetn            = 1'b0;
    bus.inst_addr_ok  = 1'b0;
    bus.inst_data_ok  = 1'b0;
    bus.inst_rdata    = 32'h0;
    br_taken          = 1'b0;
    br_target         = 32'h0;
    id_allowin        = 1'b1;
    step;
    step;
    resetn            = 1'b1;
  endtask

  // From S_REQ: accept the address, return data next cycle; ends in S_HOLD.
  task automatic fetch_one(input logic [31:0] data);
    bus.inst_addr_ok = 1'b1;
    step;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = data;
    step;
    bus.inst_data_ok = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset;
    resetn = 1'b0;
    step;
    n_cmp++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", bus.inst_req); end
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", if_valid); end
    n_cmp++; if (if_pc !== RST_PC) begin n_fail++; $display("FAIL rst_pc: got %h want %h", if_pc, RST_PC); end
    n_cmp++; if (if_inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h want 0", if_inst); end
    n_cmp++; if (if_ex !== 1'b0) begin n_fail++; $display("FAIL rst_ex: got %b want 0", if_ex); end
    resetn = 1'b1;
    step;
    n_cmp++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== RST_PC) begin n_fail++; $display("FAIL rst_first_req: req %b addr %h want 1 %h", bus.inst_req, bus.inst_addr, RST_PC); end
    fetch_one(32'h1234_5678);
    n_cmp++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b want 1", if_valid); end
    resetn = 1'b0;
    #2;
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b want 0", if_valid); end
    n_cmp++; if (if_inst !== 32'h0) begin n_fail++; $display("FAIL rst_async_inst: got %h want 0", if_inst); end
    step;
    resetn = 1'b1;
  endtask

  task automatic test_sequential;
    logic [31:0] d [3];
    d[0] = 32'h2401_0001;
    d[1] = 32'h2402_0002;
    d[2] = 32'h2403_0003;
    apply_reset;
    step;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== RST_PC + 32'(4 * k)) begin n_fail++; $display("FAIL seq_req[%0d]: req %b addr %h want 1 %h", k, bus.inst_req, bus.inst_addr, RST_PC + 32'(4 * k)); end
      n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL seq_idle_valid[%0d]: got %b want 0", k, if_valid); end
      fetch_one(d[k]);
      n_cmp++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b want 1", k, if_valid); end
      n_cmp++; if (if_inst !== d[k]) begin n_fail++; $display("FAIL seq_inst[%0d]: got %h want %h", k, if_inst, d[k]); end
      n_cmp++; if (if_pc !== RST_PC + 32'(4 * k)) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", k, if_pc, RST_PC + 32'(4 * k)); end
      step;
    end
    n_cmp++; if (bus.inst_addr !== 32'h8000_000C) begin n_fail++; $display("FAIL seq_next_addr: got %h want 8000000c", bus.inst_addr); end
  endtask

  task automatic test_stall;
    apply_reset;
    step;
    fetch_one(32'h2401_0001);
    step;
    fetch_one(32'h2402_0002);
    id_allowin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, if_valid); end
      n_cmp++; if (if_pc !== 32'h8000_0004) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want 80000004", i, if_pc); end
      n_cmp++; if (if_inst !== 32'h2402_0002) begin n_fail++; $display("FAIL stall_inst[%0d]: got %h want 24020002", i, if_inst); end
      n_cmp++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %b want 0", i, bus.inst_req); end
      bus.inst_data_ok = (i == 2);
      bus.inst_rdata   = 32'hBAD0_BAD0;
      step;
    end
    bus.inst_data_ok = 1'b0;
    id_allowin = 1'b1;
    step;
    n_cmp++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h8000_0008) begin n_fail++; $display("FAIL stall_next: req %b addr %h want 1 80000008", bus.inst_req, bus.inst_addr); end
  endtask

  task automatic test_branch_in_wait;
    apply_reset;
    step;
    bus.inst_addr_ok = 1'b1;
    step;
    bus.inst_addr_ok = 1'b0;
    br_taken  = 1'b1;
    br_target = 32'h8000_1000;
    n_cmp++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL bw_wait_req: got %b want 0", bus.inst_req); end
    step;
    br_taken = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hDEAD_BEEF;
    step;
    bus.inst_data_ok = 1'b0;
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL bw_drop_valid: got %b want 0", if_valid); end
    n_cmp++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h8000_1000) begin n_fail++; $display("FAIL bw_redirect: req %b addr %h want 1 80001000", bus.inst_req, bus.inst_addr); end
    fetch_one(32'h2405_0005);
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_1000 || if_inst !== 32'h2405_0005) begin n_fail++; $display("FAIL bw_refetch: valid %b pc %h inst %h want 1 80001000 24050005", if_valid, if_pc, if_inst); end
  endtask

  task automatic test_branch_with_data;
    apply_reset;
    step;
    bus.inst_addr_ok = 1'b1;
    step;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hDEAD_BEEF;
    br_taken  = 1'b1;
    br_target = 32'h8000_1000;
    step;
    bus.inst_data_ok = 1'b0;
    br_taken = 1'b0;
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL bd_drop_valid: got %b want 0", if_valid); end
    n_cmp++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h8000_1000) begin n_fail++; $display("FAIL bd_redirect: req %b addr %h want 1 80001000", bus.inst_req, bus.inst_addr); end
    fetch_one(32'h2406_0006);
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_1000 || if_inst !== 32'h2406_0006) begin n_fail++; $display("FAIL bd_refetch: valid %b pc %h inst %h want 1 80001000 24060006", if_valid, if_pc, if_inst); end
  endtask

  task automatic test_branch_in_req;
    apply_reset;
    step;
    for (int k = 0; k < 4; k++) begin
      fetch_one(32'h2400_0000 + 32'(k));
      step;
    end
    n_cmp++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h8000_0010) begin n_fail++; $display("FAIL br_pre: req %b addr %h want 1 80000010", bus.inst_req, bus.inst_addr); end
    br_taken  = 1'b1;
    br_target = 32'h8000_2000;
    step;
    br_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h8000_2000) begin n_fail++; $display("FAIL br_req_addr[%0d]: req %b addr %h want 1 80002000", i, bus.inst_req, bus.inst_addr); end
      step;
    end
    fetch_one(32'h2407_0007);
    n_cmp++; if (if_pc !== 32'h8000_2000 || if_inst !== 32'h2407_0007) begin n_fail++; $display("FAIL br_refetch: pc %h inst %h want 80002000 24070007", if_pc, if_inst); end
  endtask

  task automatic test_hold_redirect_wrap;
    apply_reset;
    step;
    fetch_one(32'h2401_0001);
    br_taken   = 1'b1;
    br_target  = 32'hFFFF_FFFC;
    id_allowin = 1'b1;
    step;
    br_taken = 1'b0;
    n_cmp++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL hr_redirect: req %b addr %h want 1 fffffffc", bus.inst_req, bus.inst_addr); end
    fetch_one(32'h2408_0008);
    n_cmp++; if (if_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL hr_pc: got %h want fffffffc", if_pc); end
    step;
    n_cmp++; if (bus.inst_addr !== 32'h0000_0000) begin n_fail++; $display("FAIL hr_wrap: got %h want 00000000", bus.inst_addr); end
  endtask

  task automatic test_adef;
    apply_reset;
    step;
    fetch_one(32'h240A_000A);
    br_taken  = 1'b1;
    br_target = 32'h8000_0002;
    step;
    br_taken = 1'b0;
`ifdef IF_ADEF_EN
    n_cmp++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL adef_req: got %b want 0", bus.inst_req); end
    step;
    n_cmp++; if (if_valid !== 1'b1 || if_ex !== 1'b1) begin n_fail++; $display("FAIL adef_flags: valid %b ex %b want 1 1", if_valid, if_ex); end
    n_cmp++; if (if_pc !== 32'h8000_0002 || if_inst !== 32'h0) begin n_fail++; $display("FAIL adef_data: pc %h inst %h want 80000002 00000000", if_pc, if_inst); end
    id_allowin = 1'b1;
    step;
    n_cmp++; if (if_ex !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL adef_clear: ex %b valid %b want 0 0", if_ex, if_valid); end
`else
    n_cmp++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h8000_0002) begin n_fail++; $display("FAIL adef_off_req: req %b addr %h want 1 80000002", bus.inst_req, bus.inst_addr); end
    fetch_one(32'h2409_0009);
    n_cmp++; if (if_pc !== 32'h8000_0002 || if_inst !== 32'h2409_0009 || if_ex !== 1'b0) begin n_fail++; $display("FAIL adef_off_fetch: pc %h inst %h ex %b want 80000002 24090009 0", if_pc, if_inst, if_ex); end
`endif
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_stall;
    test_branch_in_wait;
    test_branch_with_data;
    test_branch_in_req;
    test_hold_redirect_wrap;
    test_adef;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
